line_mem_ctrl: RTL
==================

// Module: line_mem_ctrl
// PURPOSE
//   Sequencer/arbiter for one MEM_SIZE-entry 1-D line memory (16-bit words, addressed write
//   port, full-width parallel read, single-word chip read port).
//   Fills the memory from a valid/ready pixel stream and presents each full line to the conv
//   engine with a valid/ready handshake.
//   Shares the memory address bus between the fill stream and a host word-readback port.
//   Guarantees wr_en and rd_en are never asserted together.
// PARAMETERS
//   DW        16  data word width
//   MEM_SIZE  10  words per line
//   MEM_ADDR  4   address width, >= clog2(MEM_SIZE)
//   CNT_W     16  line counter width (LINE_CNT_EN only)
// PORTS
//   clk            in   1           clock, rising edge
//   reset          in   1           asynchronous, active-low
//   clr            in   1           synchronous abort of current fill
//   s_data         in   DW          pixel stream data (signed)
//   s_valid        in   1           pixel valid
//   s_ready        out  1           pixel accepted when s_valid&&s_ready
//   line_valid     out  1           full line available on memory parallel output
//   line_ready     in   1           conv engine consumes line
//   host_req       in   1           host word read request (level, one read per granted cycle)
//   host_addr      in   MEM_ADDR    host read address
//   host_grant     out  1           host request served this cycle
//   host_rvalid    out  1           host_rdata valid (1 cycle after grant)
//   host_rdata     out  DW          registered readback word
//   mem_data_in    out  DW          to memory data_in
//   mem_in_add     out  MEM_ADDR    to memory in_add
//   mem_wr_en      out  1           to memory wr_en
//   mem_rd_en      out  1           to memory rd_en
//   mem_chiprd_en  out  1           to memory chiprd_en
//   mem_chip_data  in   DW          from memory chip_data_out
//   line_cnt       out  CNT_W       lines consumed (LINE_CNT_EN only)
// BEHAVIOUR
//   States: FILL, FULL. Reset -> FILL, wr_ptr=0, last_host=0. All registered outputs reset to 0.
//   FILL:
//     - s_ready = !host_grant.
//     - Write beat: mem_wr_en = s_valid && s_ready; mem_in_add = wr_ptr; mem_data_in = s_data
//       (combinational, written at the next clk edge).
//     - Each beat increments wr_ptr.
//     - Beat at wr_ptr == MEM_SIZE-1 -> next state FULL, wr_ptr=0.
//   FULL:
//     - mem_rd_en = 1, line_valid = 1, s_ready = 0, mem_wr_en = 0.
//     - line_ready -> FILL on the next cycle; the next line starts at addr 0.
//   Host arbitration:
//     - host_grant = host_req && !(state==FILL && s_valid && last_host).
//     - When granted: mem_chiprd_en = 1, mem_in_add = host_addr.
//     - last_host <= host_grant in FILL, so a held host_req alternates with the stream.
//       No starvation either way.
//     - In FULL the host is always granted; the memory keeps line data stable.
//   Host readback:
//     - host_rdata <= mem_chip_data and host_rvalid <= 1 on the cycle after grant.
//     - Otherwise host_rvalid <= 0 and host_rdata holds its value.
//   host_addr >= MEM_SIZE: still granted; host_rdata returns 0 (memory returns 0).
//   Default outputs: mem_in_add = wr_ptr whenever no host grant; mem_chiprd_en = 0.
//   clr:
//     - Forces FILL, wr_ptr=0, last_host=0 next cycle; any pending line_valid is dropped.
//     - Memory contents are not cleared.
//     - A stream beat in the same cycle is still written but not counted.
//     - clr has priority over line_ready.
//   Reset mid-fill: partial line is discarded (wr_ptr=0); memory is cleared by its own reset.
// CONFIGURATION
//   LINE_CNT_EN defined:
//     - line_cnt increments on each line_valid&&line_ready, wraps at 2^CNT_W.
//     - Reset value 0; unaffected by clr.
//   LINE_CNT_EN undefined: line_cnt port and counter are absent.
// TESTING
//   T1 stream 1..10 with s_valid continuous -> writes addr 0..9; line_valid high at cycle 11;
//      parallel output = {1,2,...,10}; mem_wr_en never overlaps mem_rd_en.
//   T2 hold line_ready=0 for 5 cycles in FULL with s_valid=1 -> s_ready=0, no writes;
//      line_ready=1 -> next beat written at addr 0.
//   T3 host_req held with host_addr=3 during streaming -> grants alternate with writes;
//      host_rvalid 1 cycle after each grant; data = current mem[3].
//   T4 host_addr=12 -> host_grant=1, host_rdata=0 next cycle.
//   T5 clr after 6 beats -> s_ready next cycle; next beat written at addr 0;
//      line_valid only after 10 further beats.
//   T6 (LINE_CNT_EN) 3 lines consumed -> line_cnt=3; reset low mid-fill -> line_cnt=0,
//      line_valid=0, wr_ptr=0.

Source files
------------

// File: rtl/line_mem_ctrl_if.sv
// rtl/line_mem_ctrl_if.sv - pixel stream, line handshake and host readback bundle for line_mem_ctrl
interface line_mem_ctrl_if #(
  parameter int DW       = 16,
  parameter int MEM_ADDR = 4
);
  logic [DW-1:0]       s_data;
  logic                s_valid;
  logic                s_ready;
  logic                line_valid;
  logic                line_ready;
  logic                host_req;
  logic [MEM_ADDR-1:0] host_addr;
  logic                host_grant;
  logic                host_rvalid;
  logic [DW-1:0]       host_rdata;

  modport master (
    output s_data, s_valid, line_ready, host_req, host_addr,
    input  s_ready, line_valid, host_grant, host_rvalid, host_rdata
  );

  modport slave (
    input  s_data, s_valid, line_ready, host_req, host_addr,
    output s_ready, line_valid, host_grant, host_rvalid, host_rdata
  );
endinterface

// File: rtl/line_mem_ctrl.sv
// rtl/line_mem_ctrl.sv - line memory fill/present sequencer with host readback arbitration
// Optional line counter enabled by defining LINE_CNT_EN.
module line_mem_ctrl #(
  parameter int DW       = 16,
  parameter int MEM_SIZE = 10,
  parameter int MEM_ADDR = 4
`ifdef LINE_CNT_EN
  , parameter int CNT_W  = 16
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  line_mem_ctrl_if.slave      bus,
  output logic [DW-1:0]       mem_data_in,
  output logic [MEM_ADDR-1:0] mem_in_add,
  output logic                mem_wr_en,
  output logic                mem_rd_en,
  output logic                mem_chiprd_en,
  input  logic [DW-1:0]       mem_chip_data
`ifdef LINE_CNT_EN
  , output logic [CNT_W-1:0]  line_cnt
`endif
);

  typedef enum logic {FILL, FULL} state_t;

  localparam logic [MEM_ADDR-1:0] LAST_ADDR = MEM_ADDR'(MEM_SIZE - 1);

  state_t              state, state_nxt;
  logic [MEM_ADDR-1:0] wr_ptr, wr_ptr_nxt;
  logic                last_host, last_host_nxt;
  logic                grant;
  logic                beat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      wr_ptr    <= '0;
      last_host <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      last_host <= last_host_nxt;
    end
  end

  // The host loses only when it won the previous FILL cycle and a pixel is waiting.
  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    last_host_nxt  = last_host;
    bus.s_ready    = 1'b0;
    bus.line_valid = 1'b0;
    mem_rd_en      = 1'b0;
    beat           = 1'b0;
    grant          = bus.host_req && !(state == FILL && bus.s_valid && last_host);
    unique case (state)
      FILL: begin
        bus.s_ready   = !grant;
        beat          = bus.s_valid && !grant;
        last_host_nxt = grant;
        if (beat) begin
          if (wr_ptr == LAST_ADDR) begin
            wr_ptr_nxt = '0;
            state_nxt  = FULL;
          end else begin
            wr_ptr_nxt = wr_ptr + 1'b1;
          end
        end
      end
      FULL: begin
        bus.line_valid = 1'b1;
        mem_rd_en      = 1'b1;
        if (bus.line_ready) state_nxt = FILL;
      end
    endcase
    if (clr) begin
      state_nxt     = FILL;
      wr_ptr_nxt    = '0;
      last_host_nxt = 1'b0;
    end
  end

  assign mem_wr_en      = beat;
  assign mem_data_in    = bus.s_data;
  assign mem_chiprd_en  = grant;
  assign mem_in_add     = grant ? bus.host_addr : wr_ptr;
  assign bus.host_grant = grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.host_rvalid <= 1'b0;
      bus.host_rdata  <= '0;
    end else begin
      bus.host_rvalid <= grant;
      if (grant) bus.host_rdata <= mem_chip_data;
    end
  end

`ifdef LINE_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_cnt <= '0;
    end else if (bus.line_valid && bus.line_ready) begin
      line_cnt <= line_cnt + 1'b1;
    end
  end
`endif

endmodule
